// File: rtl/mul_approx_pkg.sv
// Shared types and helpers for the parametrised approximate multiplier pipe.
package mul_approx_pkg;

   // Operating modes carried with every beat.
   typedef enum logic [1:0] {
      MODE_EXACT    = 2'd0,
      MODE_COLTRUNC = 2'd1,
      MODE_OPTRUNC  = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_e;

   // Operand width limits and the default product width (2 x operand width).
   localparam int MIN_WIDTH      = 4;
   localparam int MAX_WIDTH      = 16;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_PROD_W     = 2 * DEF_WIDTH;

   // Product width for a given operand width.
   function automatic int prod_w(input int width);
      return 2 * width;
   endfunction

   // Saturating add clamped to a w-bit unsigned maximum (w <= 64).
   // Operands are expected to already fit in w bits.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int          w);
      logic [64:0] sum;
      logic [63:0] max_val;
      max_val = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      sum     = {1'b0, a} + {1'b0, b};
      if (sum[64] || (sum[63:0] > max_val)) begin
         return max_val;
      end
      return sum[63:0];
   endfunction

endpackage

// File: rtl/mul_approx_core.sv
// Combinational multiplier array: exact product plus the mode-selected
// approximate product (column-truncated or operand-truncated).
module mul_approx_core
   import mul_approx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TRUNC = 4
) (
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [1:0]         mode,
   output logic [2*WIDTH-1:0] P_exact,
   output logic [2*WIDTH-1:0] P_approx
);

   localparam int PW = 2 * WIDTH;
   // Rounding compensation for the dropped low columns (half the lowest kept weight).
   localparam logic [PW-1:0] COMP =
      (TRUNC > 0) ? (PW'(1) << ((TRUNC > 0) ? TRUNC - 1 : 0)) : '0;
   // Operand mask for mode 2: clear the low TRUNC/2 bits.
   localparam logic [WIDTH-1:0] OP_KEEP = {WIDTH{1'b1}} << (TRUNC / 2);

   logic [PW-1:0] col_trunc;

   // One row per multiplicand bit; partial-product bits in columns below
   // TRUNC are masked out, rows are accumulated down the chain.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
      logic [WIDTH-1:0] keep;
      logic [PW-1:0]    row;
      logic [PW-1:0]    acc;

      // Keep B[j] only where column gi+j survives truncation.
      always_comb begin
         keep = '0;
         for (int j = 0; j < WIDTH; j++) begin
            keep[j] = ((gi + j) >= TRUNC);
         end
      end

      assign row = A[gi] ? (PW'(B & keep) << gi) : '0;

      if (gi == 0) begin : g_first
         assign acc = row;
      end else begin : g_chain
         assign acc = g_row[gi-1].acc + row;
      end
   end

   assign col_trunc = g_row[WIDTH-1].acc + COMP;
   assign P_exact   = PW'(A) * PW'(B);

   // Per-beat mode selection; reserved mode falls back to the exact product.
   always_comb begin
      P_approx = P_exact;
      case (mode_e'(mode))
         MODE_COLTRUNC: P_approx = col_trunc;
         MODE_OPTRUNC:  P_approx = PW'(A & OP_KEEP) * PW'(B & OP_KEEP);
         default:       P_approx = P_exact;
      endcase
   end

endmodule

// File: rtl/mul_approx_pipe.sv
// Pipelined approximate multiplier with valid/ready stream and an in-system
// error monitor (beat count and accumulated |exact - approx|).
module mul_approx_pipe
   import mul_approx_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int TRUNC  = 4,
   parameter int PIPE   = 2,
   parameter int STAT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic [1:0]          mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*WIDTH-1:0]  O,
   output logic [1:0]          out_mode,
   output logic                mode_err,
   input  logic                stat_clear,
   output logic [STAT_W-1:0]   stat_count,
   output logic [STAT_W-1:0]   stat_err_sum
);

   localparam int PW = 2 * WIDTH;

   logic          en;
   logic [PW-1:0] core_exact;
   logic [PW-1:0] core_approx;
   logic [PW-1:0] fin_exact;
   logic [PW-1:0] err;

   logic [STAT_W-1:0] stat_count_q, stat_count_d;
   logic [STAT_W-1:0] stat_err_sum_q, stat_err_sum_d;

   mul_approx_core #(
      .WIDTH (WIDTH),
      .TRUNC (TRUNC)
   ) u_core (
      .A        (A),
      .B        (B),
      .mode     (mode),
      .P_exact  (core_exact),
      .P_approx (core_approx)
   );

   // Whole pipe advances together; a full output slot with no taker freezes it.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Stage 0 holds the array result; later stages are pure retiming and
   // carry bubbles as invalid slots.
   for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
      logic          vld_q, vld_d;
      logic [1:0]    mode_q, mode_d;
      logic [PW-1:0] exact_q, exact_d;
      logic [PW-1:0] approx_q, approx_d;

      if (gi == 0) begin : g_first
         // Capture the multiplier array output when the pipe advances.
         always_comb begin
            vld_d    = vld_q;
            mode_d   = mode_q;
            exact_d  = exact_q;
            approx_d = approx_q;
            if (en) begin
               vld_d    = in_valid;
               mode_d   = mode;
               exact_d  = core_exact;
               approx_d = core_approx;
            end
         end
      end else begin : g_retime
         // Shift the previous stage forward when the pipe advances.
         always_comb begin
            vld_d    = vld_q;
            mode_d   = mode_q;
            exact_d  = exact_q;
            approx_d = approx_q;
            if (en) begin
               vld_d    = g_stage[gi-1].vld_q;
               mode_d   = g_stage[gi-1].mode_q;
               exact_d  = g_stage[gi-1].exact_q;
               approx_d = g_stage[gi-1].approx_q;
            end
         end
      end

      // Stage registers; reset drops every in-flight beat.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q    <= 1'b0;
            mode_q   <= '0;
            exact_q  <= '0;
            approx_q <= '0;
         end else begin
            vld_q    <= vld_d;
            mode_q   <= mode_d;
            exact_q  <= exact_d;
            approx_q <= approx_d;
         end
      end
   end

   assign out_valid = g_stage[PIPE-1].vld_q;
   assign O         = g_stage[PIPE-1].approx_q;
   assign out_mode  = g_stage[PIPE-1].mode_q;
   assign mode_err  = (g_stage[PIPE-1].mode_q == MODE_RSVD);
   assign fin_exact = g_stage[PIPE-1].exact_q;

   // Absolute error of the beat at the output slot.
   always_comb begin
      err = (fin_exact >= O) ? (fin_exact - O) : (O - fin_exact);
   end

   // Statistics: clear wins over a coincident handshake; both counters saturate.
   always_comb begin
      stat_count_d   = stat_count_q;
      stat_err_sum_d = stat_err_sum_q;
      if (stat_clear) begin
         stat_count_d   = '0;
         stat_err_sum_d = '0;
      end else if (out_valid && out_ready) begin
         stat_count_d   = STAT_W'(sat_add(64'(stat_count_q), 64'd1, STAT_W));
         stat_err_sum_d = STAT_W'(sat_add(64'(stat_err_sum_q), 64'(err), STAT_W));
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_count_q   <= '0;
         stat_err_sum_q <= '0;
      end else begin
         stat_count_q   <= stat_count_d;
         stat_err_sum_q <= stat_err_sum_d;
      end
   end

   assign stat_count   = stat_count_q;
   assign stat_err_sum = stat_err_sum_q;

endmodule

// File: doc/mul_approx_pipe.md
Name: mul_approx_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 approximate multipliers in the library.
- Computes an unsigned WIDTH x WIDTH product in one of three run-time-selectable modes: exact, column-truncated, operand-truncated.
- Uses a valid/ready stream interface.
- Carries an on-chip error monitor that accumulates |exact - approx| and a transaction count, giving in-system MAE measurement for each tagged mode.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH; legal range 4..16.
- TRUNC, 4, in mode 1, number of low product columns removed from the partial-product array; in mode 2, operand bits zeroed = TRUNC/2; legal range 0..WIDTH.
- PIPE, 2, register stages from input to output; must be >= 1.
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- A  in  WIDTH  multiplicand, unsigned.
- B  in  WIDTH  multiplier, unsigned.
- mode  in  2  0 = exact, 1 = column-truncated, 2 = operand-truncated, 3 = reserved.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- O  out  2*WIDTH  product.
- out_mode  out  2  mode tag travelling with O.
- mode_err  out  1  set with a beat that entered with mode 3.
- stat_clear  in  1  clear statistics.
- stat_count  out  STAT_W  accepted output beats since reset/clear.
- stat_err_sum  out  STAT_W  sum of |exact - O| over those beats.

Behaviour:
- Reset: all stage valids = 0, out_valid = 0, O = 0, out_mode = 0, mode_err = 0, stat_count = 0, stat_err_sum = 0. Reset mid-operation discards all in-flight beats; nothing is counted.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - O, out_mode and mode_err are held stable while out_valid && !out_ready.
- Flow control: global pipeline enable en = !out_valid || out_ready; in_ready = en, combinational, no registers.
- Latency and throughput:
  - Exactly PIPE cycles from acceptance to out_valid when never stalled.
  - Throughput is 1 beat/cycle.
  - Bubbles propagate as invalid stages; they do not collapse.
- Arithmetic, all unsigned, exact product P = A*B (2*WIDTH bits):
  - Mode 0: O = P.
  - Mode 1: every partial-product bit A[i]&B[j] with i+j < TRUNC is dropped. If TRUNC > 0, add compensation 2^(TRUNC-1). Result wraps modulo 2^(2*WIDTH). TRUNC = 0 makes mode 1 identical to mode 0.
  - Mode 2: O = (A & ~M) * (B & ~M), where M = 2^(TRUNC/2) - 1, with integer division.
  - Mode 3: computed as mode 0 with out_mode = 3 and mode_err = 1.
- Stage split: the partial-product array and mode selection sit in stage 1; the exact product is carried alongside; error |P - O| is computed in the final stage. With PIPE > 2, the extra stages are placed after the array as retiming registers.
- Statistics, updated on an output handshake:
  - stat_count += 1.
  - stat_err_sum += |P - O|.
  - Both saturate at 2^STAT_W - 1; no wrap.
  - stat_clear has priority: counters become 0 and a coincident handshake is not counted.
  - Stalled cycles never count.
- Boundaries:
  - Operands 0 give O = 0 in modes 0 and 2; mode 1 still adds the compensation.
  - All-ones operands must not overflow in mode 0.
  - Mode is sampled per beat, so mixed-mode streams are legal.

Decomposition:
- Package mul_approx_pkg:
  - mode enum: MODE_EXACT = 0, MODE_COLTRUNC = 1, MODE_OPTRUNC = 2, MODE_RSVD = 3.
  - Function for the saturating add.
  - Localparam for the product width.
- Sub-module mul_approx_core: purely combinational. Takes A, B, mode and outputs P_exact and P_approx. The pipe wraps it with registers, handshake and statistics.

Test Plan:
- WIDTH = 8, TRUNC = 4, PIPE = 2; mode 0, A = 255, B = 255, out_ready = 1 -> two cycles later O = 65025, out_mode = 0, stat_count = 1, stat_err_sum = 0.
- Mode 1, A = 15, B = 15 -> O = 184 (225 - 49 + 8); stat_err_sum += 41. Mode 2, A = 15, B = 15 -> O = 144; err += 81.
- Mode 1, A = 0, B = 0 -> O = 8, err = 8. Mode 3, A = 3, B = 5 -> O = 15, mode_err = 1, out_mode = 3.
- Stream 6 back-to-back beats with out_ready low for cycles 3-5 -> in_ready low during the stall; O held stable; no beat lost or duplicated; stat_count = 6 at end.
- stat_clear asserted in the same cycle as an output handshake -> stat_count = 0 and stat_err_sum = 0 next cycle. rst asserted with 2 beats in flight -> out_valid = 0 next cycle, and neither beat ever appears.
- Force stat_err_sum to 2^32 - 2 (STAT_W = 32) via a bench backdoor, then send a mode 1 beat with error 41 -> stat_err_sum = 2^32 - 1 (saturated).
